// File: rtl/hough_frame_sequencer.sv
// Per-frame scheduler for the Hough vote histograms: clears both RAMs during
// vsync, gates voting for the active frame, then scans for and publishes the peaks.
module hough_frame_sequencer #(
    parameter int X_BINS    = 640,
    parameter int Y_BINS    = 480,
    parameter int CNT_W     = 12,
    parameter int MIN_VOTES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vsync_in,
    input  logic             enable,
    output logic             acc_en,
    output logic [9:0]       ram_addr,
    output logic             x_we,
    output logic             y_we,
    input  logic [CNT_W-1:0] x_rdata,
    input  logic [CNT_W-1:0] y_rdata,
    output logic [9:0]       ideal_x,
    output logic [8:0]       ideal_y,
    output logic             ideal_valid,
    output logic             no_target,
    output logic             overrun,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        WAIT_FALL,
        ACCUM,
        SCAN,
        PUBLISH
    } state_t;

    localparam logic [9:0]       ADDR_LAST = 10'(X_BINS - 1);
    localparam logic [10:0]      SCAN_LAST = 11'(X_BINS);
    localparam logic [10:0]      Y_LIMIT   = 11'(Y_BINS);
    localparam logic [CNT_W-1:0] THRESH    = CNT_W'(MIN_VOTES);

    state_t           state;
    logic             vs_meta;
    logic             vs_sync;
    logic             vs_prev;
    logic             rise;
    logic             fall;
    logic [10:0]      scan_cnt;
    logic [CNT_W-1:0] x_max;
    logic [CNT_W-1:0] y_max;
    logic [9:0]       x_idx;
    logic [8:0]       y_idx;

    logic [9:0]       cmp_idx;
    logic             cmp_on;
    logic             x_take;
    logic             y_take;
    logic [CNT_W-1:0] x_max_nx;
    logic [CNT_W-1:0] y_max_nx;
    logic [9:0]       x_idx_nx;
    logic [8:0]       y_idx_nx;
    logic             peak_hit;

    // Two-flop synchronizer followed by a single edge-detect flop.
    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vs_meta <= 1'b0;
            vs_sync <= 1'b0;
            vs_prev <= 1'b0;
        end else begin
            vs_meta <= vsync_in;
            vs_sync <= vs_meta;
            vs_prev <= vs_sync;
        end
    end

    assign rise = vs_sync & ~vs_prev;
    assign fall = ~vs_sync & vs_prev;

    // Read data returned this cycle belongs to the address presented one cycle ago.
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        cmp_idx  = scan_cnt[9:0] - 10'd1;
        cmp_on   = (state == SCAN) && (scan_cnt != 11'd0);
        x_take   = cmp_on && (x_rdata > x_max);
        y_take   = cmp_on && ({1'b0, cmp_idx} < Y_LIMIT) && (y_rdata > y_max);
        x_max_nx = x_take ? x_rdata : x_max;
        y_max_nx = y_take ? y_rdata : y_max;
        x_idx_nx = x_take ? cmp_idx : x_idx;
        y_idx_nx = y_take ? cmp_idx[8:0] : y_idx;
        peak_hit = (x_max_nx >= THRESH) && (y_max_nx >= THRESH);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            acc_en      <= 1'b0;
            ram_addr    <= '0;
            x_we        <= 1'b0;
            y_we        <= 1'b0;
            ideal_x     <= '0;
            ideal_y     <= '0;
            ideal_valid <= 1'b0;
            no_target   <= 1'b0;
            overrun     <= 1'b0;
            busy        <= 1'b0;
            scan_cnt    <= '0;
            x_max       <= '0;
            y_max       <= '0;
            x_idx       <= '0;
            y_idx       <= '0;
        end else begin
            ideal_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise && enable) begin
                        state    <= CLEAR;
                        ram_addr <= '0;
                        x_we     <= 1'b1;
                        y_we     <= 1'b1;
                        busy     <= 1'b1;
                    end
                end

                CLEAR: begin
                    if (ram_addr == ADDR_LAST) begin
                        ram_addr <= '0;
                        x_we     <= 1'b0;
                        y_we     <= 1'b0;
                        busy     <= 1'b0;
                        // Vsync already low here means the frame start went by during the clear.
                        if (vs_sync) begin
                            state <= WAIT_FALL;
                        end else begin
                            state   <= IDLE;
                            overrun <= 1'b1;
                        end
                    end else begin
                        ram_addr <= ram_addr + 10'd1;
                        y_we     <= (({1'b0, ram_addr} + 11'd1) < Y_LIMIT);
                    end
                end

                WAIT_FALL: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (fall) begin
                        state  <= ACCUM;
                        acc_en <= 1'b1;
                    end
                end

                ACCUM: begin
                    if (!enable) begin
                        state  <= IDLE;
                        acc_en <= 1'b0;
                    end else if (rise) begin
                        state    <= SCAN;
                        acc_en   <= 1'b0;
                        busy     <= 1'b1;
                        ram_addr <= '0;
                        scan_cnt <= '0;
                        x_max    <= '0;
                        y_max    <= '0;
                        x_idx    <= '0;
                        y_idx    <= '0;
                    end
                end

                SCAN: begin
                    x_max <= x_max_nx;
                    y_max <= y_max_nx;
                    x_idx <= x_idx_nx;
                    y_idx <= y_idx_nx;
                    if (scan_cnt == SCAN_LAST) begin
                        // Decide on the post-compare maxima so the strobe lands in PUBLISH itself.
                        state    <= PUBLISH;
                        ram_addr <= '0;
                        if (peak_hit) begin
                            ideal_x     <= x_idx_nx;
                            ideal_y     <= y_idx_nx;
                            ideal_valid <= 1'b1;
                            no_target   <= 1'b0;
                        end else begin
                            no_target   <= 1'b1;
                        end
                    end else begin
                        scan_cnt <= scan_cnt + 11'd1;
                        if (ram_addr != ADDR_LAST) begin
                            ram_addr <= ram_addr + 10'd1;
                        end
                    end
                end

                PUBLISH: begin
                    // The vsync pulse that closed the frame doubles as the next clear window.
                    if (enable) begin
                        state    <= CLEAR;
                        ram_addr <= '0;
                        x_we     <= 1'b1;
                        y_we     <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state    <= IDLE;
                    acc_en   <= 1'b0;
                    x_we     <= 1'b0;
                    y_we     <= 1'b0;
                    busy     <= 1'b0;
                    ram_addr <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hough_frame_sequencer.sv
// Self-checking bench for hough_frame_sequencer: RAM/accumulator model plus a
// vote-count reference that predicts the published peak of every frame.
module tb_hough_frame_sequencer;

    localparam int XB = 8;
    localparam int YB = 6;
    localparam int CW = 12;
    localparam int MV = 2;

    logic          clk      = 1'b0;
    logic          reset    = 1'b0;
    logic          vsync_in = 1'b0;
    logic          enable   = 1'b0;
    logic          acc_en;
    logic [9:0]    ram_addr;
    logic          x_we;
    logic          y_we;
    logic [CW-1:0] x_rdata  = '0;
    logic [CW-1:0] y_rdata  = '0;
    logic [9:0]    ideal_x;
    logic [8:0]    ideal_y;
    logic          ideal_valid;
    logic          no_target;
    logic          overrun;
    logic          busy;

    wire [35:0] outs = {acc_en, ram_addr, x_we, y_we, ideal_x, ideal_y,
                        ideal_valid, no_target, overrun, busy};

    hough_frame_sequencer #(
        .X_BINS    (XB),
        .Y_BINS    (YB),
        .CNT_W     (CW),
        .MIN_VOTES (MV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .vsync_in    (vsync_in),
        .enable      (enable),
        .acc_en      (acc_en),
        .ram_addr    (ram_addr),
        .x_we        (x_we),
        .y_we        (y_we),
        .x_rdata     (x_rdata),
        .y_rdata     (y_rdata),
        .ideal_x     (ideal_x),
        .ideal_y     (ideal_y),
        .ideal_valid (ideal_valid),
        .no_target   (no_target),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int exp_ix = 0;
    int exp_iy = 0;
    int exp_ovr = 0;

    // Vote RAMs and the accumulator that feeds them; votes land only while acc_en is high.
    logic [CW-1:0] xmem [XB];
    logic [CW-1:0] ymem [YB];
    logic          vx_req   = 1'b0;
    logic          vy_req   = 1'b0;
    logic          fill_req = 1'b1;
    logic [2:0]    vx_idx   = '0;
    logic [2:0]    vy_idx   = '0;

    always @(posedge clk) begin
        if (fill_req) begin
            for (int i = 0; i < XB; i++) xmem[i] <= CW'($urandom_range(1, 60));
            for (int i = 0; i < YB; i++) ymem[i] <= CW'($urandom_range(1, 60));
        end
        if (x_we && ram_addr < 10'(XB)) xmem[ram_addr[2:0]] <= '0;
        if (y_we && ram_addr < 10'(YB)) ymem[ram_addr[2:0]] <= '0;
        if (acc_en && vx_req) xmem[vx_idx] <= xmem[vx_idx] + 1'b1;
        if (acc_en && vy_req) ymem[vy_idx] <= ymem[vy_idx] + 1'b1;
        x_rdata <= (ram_addr < 10'(XB)) ? xmem[ram_addr[2:0]] : '0;
        y_rdata <= (ram_addr < 10'(YB)) ? ymem[ram_addr[2:0]] : '0;
    end

    // Passive monitor: strobe counts, clear-sequence errors and busy-without-write run length.
    int         n_valid  = 0;
    int         n_xwe    = 0;
    int         n_ywe    = 0;
    int         n_acc    = 0;
    int         clr_bad  = 0;
    int         clr_k    = 0;
    int         run      = 0;
    int         scan_run = 0;
    logic [9:0] last_vx  = '0;
    logic [8:0] last_vy  = '0;

    always @(negedge clk) begin
        if (ideal_valid) begin
            n_valid++;
            last_vx = ideal_x;
            last_vy = ideal_y;
        end
        if (x_we) begin
            n_xwe++;
            if (ram_addr != 10'(clr_k)) clr_bad++;
            if (y_we != (ram_addr < 10'(YB))) clr_bad++;
            clr_k++;
        end else begin
            clr_k = 0;
            if (y_we) clr_bad++;
        end
        if (y_we) n_ywe++;
        if (acc_en) n_acc++;
        if (busy && !x_we) begin
            run++;
        end else begin
            if (run != 0) scan_run = run;
            run = 0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Reference: the peak is the first bin holding the largest count; publish needs both >= MV.
    function automatic void ref_peak(input int cx[XB], input int cy[YB],
                                     output bit hit, output int px, output int py);
        int mx;
        int my;
        mx = 0; my = 0; px = 0; py = 0;
        foreach (cx[i]) if (cx[i] > mx) mx = cx[i];
        foreach (cy[i]) if (cy[i] > my) my = cy[i];
        for (int i = XB - 1; i >= 0; i--) if (cx[i] == mx) px = i;
        for (int i = YB - 1; i >= 0; i--) if (cy[i] == my) py = i;
        hit = (mx >= MV) && (my >= MV);
    endfunction

    task automatic cast_votes(input int cx[XB], input int cy[YB]);
        int rx[XB];
        int ry[YB];
        int left;
        rx = cx;
        ry = cy;
        left = 0;
        foreach (rx[i]) left += rx[i];
        foreach (ry[i]) left += ry[i];
        while (left > 0) begin
            int s;
            int j;
            @(negedge clk);
            vx_req = 1'b0;
            vy_req = 1'b0;
            s = $urandom_range(0, XB - 1);
            for (int k = 0; k < XB; k++) begin
                j = (s + k) % XB;
                if (rx[j] > 0) begin
                    vx_req = 1'b1; vx_idx = 3'(j); rx[j]--; left--;
                    break;
                end
            end
            s = $urandom_range(0, YB - 1);
            for (int k = 0; k < YB; k++) begin
                j = (s + k) % YB;
                if (ry[j] > 0) begin
                    vy_req = 1'b1; vy_idx = 3'(j); ry[j]--; left--;
                    break;
                end
            end
        end
        @(negedge clk);
        vx_req = 1'b0;
        vy_req = 1'b0;
    endtask

    // Drives vsync high for len cycles from a negedge, returns on the negedge that lowers it.
    task automatic vsync_pulse(input int len);
        @(negedge clk);
        vsync_in = 1'b1;
        repeat (len) @(negedge clk);
        vsync_in = 1'b0;
    endtask

    // After vsync drops, acc_en must be 0, 0, then 1 on the next three sampled cycles.
    task automatic check_acc_start(input string tag);
        logic [2:0] seq;
        seq = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seq[2 - i] = acc_en;
        end
        total++;
        if (seq !== 3'b001) $display("FAIL %s acc_start: got %b expected 001", tag, seq);
        else passed++;
    endtask

    // Ends the current ACCUM frame with a long vsync pulse and checks the publish outcome.
    task automatic finish_frame(input int cx[XB], input int cy[YB], input string tag);
        bit hit;
        int px;
        int py;
        int v0;
        ref_peak(cx, cy, hit, px, py);
        if (hit) begin
            exp_ix = px;
            exp_iy = py;
        end
        v0 = n_valid;
        vsync_pulse(25);
        check_acc_start(tag);
        total++;
        if (n_valid - v0 != (hit ? 1 : 0))
            $display("FAIL %s valid_pulses: got %0d expected %0d", tag, n_valid - v0, hit ? 1 : 0);
        else passed++;
        total++;
        if (ideal_x !== 10'(exp_ix)) $display("FAIL %s ideal_x: got %0d expected %0d", tag, ideal_x, exp_ix);
        else passed++;
        total++;
        if (ideal_y !== 9'(exp_iy)) $display("FAIL %s ideal_y: got %0d expected %0d", tag, ideal_y, exp_iy);
        else passed++;
        total++;
        if (no_target !== !hit) $display("FAIL %s no_target: got %0d expected %0d", tag, no_target, !hit);
        else passed++;
        // Nine SCAN cycles plus the single PUBLISH cycle, all busy with no writes.
        total++;
        if (scan_run != XB + 2) $display("FAIL %s scan_len: got %0d expected %0d", tag, scan_run, XB + 2);
        else passed++;
        total++;
        if (overrun !== 1'(exp_ovr)) $display("FAIL %s overrun: got %0d expected %0d", tag, overrun, exp_ovr);
        else passed++;
        if (hit) begin
            total++;
            if (last_vx !== 10'(px) || last_vy !== 9'(py))
                $display("FAIL %s strobe_coord: got %0d,%0d expected %0d,%0d", tag, last_vx, last_vy, px, py);
            else passed++;
        end
    endtask

    task automatic test_reset();
        int viol;
        int x0;
        repeat (3) @(negedge clk);
        total++;
        if (outs !== '0) $display("FAIL reset_outputs: got %h expected 0", outs);
        else passed++;
        reset = 1'b1;
        x0 = n_xwe;
        viol = 0;
        for (int p = 0; p < 6; p++) begin
            @(negedge clk);
            vsync_in = 1'b1;
            repeat ($urandom_range(1, 6)) begin
                @(negedge clk);
                if (outs !== '0) viol++;
            end
            vsync_in = 1'b0;
            repeat ($urandom_range(2, 6)) begin
                @(negedge clk);
                if (outs !== '0) viol++;
            end
        end
        total++;
        if (viol != 0) $display("FAIL idle_disabled: got %0d non-zero cycles expected 0", viol);
        else passed++;
        total++;
        if (n_xwe != x0) $display("FAIL idle_strobes: got %0d writes expected 0", n_xwe - x0);
        else passed++;
    endtask

    task automatic test_clear_window();
        int x0;
        int y0;
        int b0;
        int nz;
        @(negedge clk);
        fill_req = 1'b0;
        enable   = 1'b1;
        x0 = n_xwe;
        y0 = n_ywe;
        b0 = clr_bad;
        vsync_pulse(20);
        total++;
        if (n_xwe - x0 != XB) $display("FAIL clear_xwe: got %0d expected %0d", n_xwe - x0, XB);
        else passed++;
        total++;
        if (n_ywe - y0 != YB) $display("FAIL clear_ywe: got %0d expected %0d", n_ywe - y0, YB);
        else passed++;
        total++;
        if (clr_bad != b0) $display("FAIL clear_sequence: got %0d errors expected 0", clr_bad - b0);
        else passed++;
        nz = 0;
        foreach (xmem[i]) if (xmem[i] != '0) nz++;
        foreach (ymem[i]) if (ymem[i] != '0) nz++;
        total++;
        if (nz != 0) $display("FAIL clear_contents: got %0d non-zero bins expected 0", nz);
        else passed++;
        check_acc_start("clear");
        total++;
        if (busy !== 1'b0) $display("FAIL accum_busy: got %0d expected 0", busy);
        else passed++;
    endtask

    task automatic test_peak_publish();
        int cx[XB] = '{0, 1, 5, 5, 2, 0, 0, 0};
        int cy[YB] = '{0, 0, 0, 3, 1, 0};
        cast_votes(cx, cy);
        finish_frame(cx, cy, "peak");
    endtask

    task automatic test_threshold_miss();
        int cx[XB] = '{1, 0, 1, 0, 0, 1, 0, 0};
        int cy[YB] = '{0, 0, 0, 3, 0, 0};
        cast_votes(cx, cy);
        finish_frame(cx, cy, "miss");
    endtask

    task automatic test_random_frames();
        int cx[XB];
        int cy[YB];
        for (int f = 0; f < 5; f++) begin
            int hi;
            hi = (f % 2 == 0) ? 3 : 1;
            foreach (cx[i]) cx[i] = $urandom_range(0, hi);
            foreach (cy[i]) cy[i] = $urandom_range(0, 3);
            cast_votes(cx, cy);
            finish_frame(cx, cy, "random");
        end
    endtask

    task automatic test_abort_accum();
        int cx[XB] = '{0, 0, 4, 0, 0, 0, 0, 0};
        int cy[YB] = '{0, 4, 0, 0, 0, 0};
        int v0;
        int x0;
        cast_votes(cx, cy);
        enable = 1'b0;
        @(negedge clk);
        total++;
        if ({acc_en, busy} !== 2'b00) $display("FAIL abort_acc_en: got %b expected 00", {acc_en, busy});
        else passed++;
        v0 = n_valid;
        x0 = n_xwe;
        vsync_pulse(25);
        repeat (5) @(negedge clk);
        total++;
        if (n_valid != v0 || n_xwe != x0)
            $display("FAIL abort_no_publish: got %0d pulses %0d writes expected 0 0", n_valid - v0, n_xwe - x0);
        else passed++;
        total++;
        if (ideal_x !== 10'(exp_ix)) $display("FAIL abort_ideal_x: got %0d expected %0d", ideal_x, exp_ix);
        else passed++;
    endtask

    task automatic test_overrun();
        int a0;
        int x0;
        enable = 1'b1;
        a0 = n_acc;
        x0 = n_xwe;
        vsync_pulse(4);
        repeat (15) @(negedge clk);
        exp_ovr = 1;
        total++;
        if (overrun !== 1'b1) $display("FAIL overrun_set: got %0d expected 1", overrun);
        else passed++;
        total++;
        if (n_acc != a0) $display("FAIL overrun_acc: got %0d cycles expected 0", n_acc - a0);
        else passed++;
        total++;
        if (n_xwe - x0 != XB || busy !== 1'b0)
            $display("FAIL overrun_clear: got %0d writes busy %0d expected %0d 0", n_xwe - x0, busy, XB);
        else passed++;
        x0 = n_xwe;
        vsync_pulse(20);
        check_acc_start("recover");
        total++;
        if (n_xwe - x0 != XB) $display("FAIL recover_clear: got %0d expected %0d", n_xwe - x0, XB);
        else passed++;
        total++;
        if (overrun !== 1'b1) $display("FAIL overrun_sticky: got %0d expected 1", overrun);
        else passed++;
    endtask

    task automatic test_abort_reset();
        bit found;
        int viol;
        int x0;
        enable = 1'b0;
        @(negedge clk);
        enable   = 1'b1;
        vsync_in = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (x_we && ram_addr == 10'd4) found = 1'b1;
        end
        total++;
        if (!found) $display("FAIL reset_reach_addr4: got 0 expected 1");
        else passed++;
        reset    = 1'b0;
        vsync_in = 1'b0;
        #1;
        total++;
        if (outs !== '0) $display("FAIL reset_async: got %h expected 0", outs);
        else passed++;
        @(negedge clk);
        reset   = 1'b1;
        exp_ix  = 0;
        exp_iy  = 0;
        exp_ovr = 0;
        viol = 0;
        x0 = n_xwe;
        repeat (12) begin
            @(negedge clk);
            if (outs !== '0) viol++;
        end
        total++;
        if (viol != 0 || n_xwe != x0) $display("FAIL reset_idle: got %0d non-zero cycles expected 0", viol);
        else passed++;
        x0 = n_xwe;
        vsync_pulse(20);
        check_acc_start("post_reset");
        total++;
        if (n_xwe - x0 != XB) $display("FAIL post_reset_clear: got %0d expected %0d", n_xwe - x0, XB);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_clear_window();
        test_peak_publish();
        test_threshold_miss();
        test_random_frames();
        test_abort_accum();
        test_overrun();
        test_abort_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hough_frame_sequencer.md
Name: hough_frame_sequencer

Overview:
- Per-frame scheduler for the Hough vote accumulator.
- Owns the address/write port of two vote RAMs, one X histogram and one Y histogram. Clears both during the camera vsync pulse, gates voting during the active frame, then scans both RAMs for their peaks.
- Publishes the winning coordinate as ideal_x/ideal_y to the VGA overlay and segment display, with a one-cycle valid strobe.

Parameters:
- X_BINS, 640: X histogram depth, one bin per column.
- Y_BINS, 480: Y histogram depth; must be <= X_BINS.
- CNT_W, 12: vote count width.
- MIN_VOTES, 16: peak threshold; both peaks must reach it to publish.

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-low reset
- vsync_in  in  1  raw OV7670 VSYNC, asynchronous to clk
- enable  in  1  sequencer run enable
- acc_en  out  1  vote-gate to accumulator; 1 only in ACCUM
- ram_addr  out  10  shared clear/scan address to both RAMs
- x_we  out  1  X RAM write strobe; write data is always 0
- y_we  out  1  Y RAM write strobe; asserted only when ram_addr < Y_BINS
- x_rdata  in  CNT_W  X RAM read data, 1-cycle read latency
- y_rdata  in  CNT_W  Y RAM read data, 1-cycle read latency
- ideal_x  out  10  published X peak bin
- ideal_y  out  9  published Y peak bin
- ideal_valid  out  1  one-cycle pulse on each publish
- no_target  out  1  result of the last scan: 1 = threshold not met
- overrun  out  1  sticky: a frame was skipped
- busy  out  1  1 in CLEAR, SCAN or PUBLISH

Behaviour:
- Reset state:
  - All outputs 0.
  - State IDLE.
  - Synchronizer and edge-detect flops 0.
  - Max/index registers 0.
- vsync synchronization:
  - vsync_in passes a 2-flop synchronizer, then a 1-flop edge detector.
  - rise/fall events are single-cycle and lag vsync_in by 3 cycles.
- States: IDLE, CLEAR, WAIT_FALL, ACCUM, SCAN, PUBLISH.
- IDLE:
  - On rise with enable=1 -> CLEAR.
  - Otherwise stay.
- CLEAR:
  - ram_addr counts 0..X_BINS-1, one per cycle.
  - x_we=1 throughout; y_we=1 only while ram_addr < Y_BINS.
  - Duration: exactly X_BINS cycles.
  - Exit -> WAIT_FALL if synchronized vsync is still 1.
  - Exit -> IDLE with overrun<=1 if synchronized vsync is already 0 (the frame start was missed).
- WAIT_FALL:
  - On fall -> ACCUM.
  - enable=0 -> IDLE.
- ACCUM:
  - acc_en=1.
  - On rise -> SCAN, and acc_en drops in the same cycle as the transition.
  - enable=0 -> IDLE immediately with acc_en=0; no scan and no publish.
- SCAN:
  - ram_addr counts 0..X_BINS-1; no writes.
  - Data for address a is compared one cycle after a is presented.
  - Duration: X_BINS+1 cycles, including the trailing compare.
  - Max tracking:
    - Running maxima start at 0.
    - Update only on strictly greater, so ties keep the lowest index.
    - The Y compare is active only for indices < Y_BINS.
  - An enable change is ignored until PUBLISH completes.
- PUBLISH (1 cycle):
  - If x_max >= MIN_VOTES and y_max >= MIN_VOTES:
    - ideal_x/ideal_y <= peak indices.
    - ideal_valid=1 for this cycle.
    - no_target<=0.
  - Else:
    - ideal_x/ideal_y hold their previous values.
    - no_target<=1.
    - No valid pulse.
  - Next state: CLEAR if enable=1, else IDLE.
  - The vsync pulse that ended ACCUM is reused as the next frame's clear window.
- A rise or fall seen in CLEAR, SCAN or PUBLISH is not queued. Only the level check at the end of CLEAR decides overrun.
- overrun clears only on reset.
- Asserting reset in any state returns to IDLE with all outputs 0 asynchronously. This includes aborting a partial clear.
- Counter width: ram_addr is 10 bits, so X_BINS must be <= 1024. The counter must not wrap within a state; it is zeroed on every state entry.

Test Plan:
- Reset/idle (X_BINS=8, Y_BINS=6, MIN_VOTES=2), enable=0, vsync toggled -> state stays IDLE; all outputs 0; no RAM strobes.
- Clear window: enable=1, vsync rise held 20 cycles -> x_we high for 8 consecutive cycles with addr 0..7; y_we high only for addr 0..5; then acc_en=1 exactly 3 cycles after vsync_in falls.
- Peak publish: RAM model X={0,1,5,5,2,0,0,0}, Y={0,0,0,3,1,0}; end frame with vsync rise -> one ideal_valid pulse; ideal_x=2 (tie goes to lower index); ideal_y=3; no_target=0; SCAN lasts 9 cycles.
- Threshold miss: X peak 1, Y peak 3 -> no ideal_valid; ideal_x/ideal_y keep 2/3; no_target=1.
- Overrun: vsync pulse of 4 cycles, shorter than CLEAR -> overrun=1; state IDLE; acc_en never asserted for that frame; next long pulse recovers normally.
- Abort cases:
  - enable dropped mid-ACCUM -> acc_en 0 next cycle; IDLE; no publish.
  - reset asserted mid-CLEAR at addr 4 -> all outputs 0 immediately; after release, IDLE until the next rise.
